seq_det_prog: RTL and testbench
===============================

# seq_det_prog

Runtime-programmable Mealy sequence detector, the parametrised successor of the fixed "101" detector in the FSM block set. It detects a user-loaded serial pattern of 1..MAX_LEN bits on a 1-bit stream, with selectable overlapping or non-overlapping matching and an optional saturating match counter. It sits between a serial bit source and control logic that needs a same-cycle detect strobe.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, legal 2..32.
- CNT_W, 8: match-counter width, legal 1..16.
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived localparam).

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_enable  in  1  stream qualifier; the bit on i_seq is consumed only when high.
- i_seq  in  1  serial input bit.
- i_load  in  1  one-cycle strobe that latches i_pat, i_len and i_overlap.
- i_pat  in  MAX_LEN  pattern; i_pat[len-1] is the first bit received, i_pat[0] the last.
- i_len  in  LEN_W  pattern length; 0 disarms the block; values above MAX_LEN clamp to MAX_LEN.
- i_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- i_cnt_clr  in  1  synchronous clear of the match counter.
- o_detect  out  1  Mealy match strobe, combinational from i_seq and state.
- o_armed  out  1  high when the latched length is non-zero.
- o_det_cnt  out  CNT_W  saturating match count (see Configuration).

## Operation
- Registers: pat_r, len_r, ovl_r, hist (MAX_LEN-1 bits, hist[0] newest), fill (bits accepted since the last restart, saturating at MAX_LEN), state, cnt.
- FSM states:
  - IDLE: len_r == 0. Never detects.
  - FILL: fill < len_r-1.
  - RUN: fill >= len_r-1.
- Transitions:
  - A load with len 0 goes to IDLE.
  - A load with len 1 goes to RUN.
  - Any other load goes to FILL.
  - FILL goes to RUN when the accepted bit makes fill reach len_r-1.
  - In RUN with ovl_r = 0 and a detect, go to FILL with fill = 0. When len_r = 1, stay in RUN.
  - In RUN with ovl_r = 1, stay in RUN.
- Match: o_detect = i_enable & ~i_load & (state == RUN) & ({hist[len_r-2:0], i_seq} == pat_r[len_r-1:0]). When len_r = 1, the comparison is i_seq == pat_r[0].
- Accepted bit (i_enable = 1, i_load = 0):
  - hist shifts left with i_seq entering at hist[0].
  - fill increments (saturating).
- i_enable low: hist, fill and state hold; o_detect = 0.
- i_load has priority over i_enable. On a load:
  - Latch the pattern, the clamped length and the overlap mode.
  - Clear hist and fill.
  - The i_seq bit in that cycle is discarded and o_detect = 0.
- Pattern bits above len_r are ignored.
- With pattern 101, length 3 and overlap on, behaviour equals the legacy fixed detector, minus its reset polarity.

## Timing
- o_detect has zero-cycle latency: it asserts in the same cycle as the completing bit and must be sampled at that cycle's rising edge.
- A pattern loaded in cycle N applies to bits accepted from cycle N+1 onward.
- The earliest detect after a load is the len-th accepted bit.
- Reset values: pat_r = 0, len_r = 0, ovl_r = 0, hist = 0, fill = 0, state = IDLE, cnt = 0, o_detect = 0, o_armed = 0, o_det_cnt = 0.
- An asynchronous reset mid-stream drops all partial match progress immediately. The block is unarmed until the next load.
- o_armed is registered and updates the cycle after a load.

## Configuration
- SEQ_DET_CNT_EN defined:
  - cnt increments by 1 on every cycle with o_detect = 1.
  - cnt saturates at 2^CNT_W-1.
  - i_cnt_clr sets it to 0; clear wins over a simultaneous detect.
  - i_load does not affect cnt.
  - o_det_cnt = cnt.
- SEQ_DET_CNT_EN undefined:
  - No counter register is built.
  - o_det_cnt is tied to 0 and i_cnt_clr is ignored.

## Test plan
- Reset, then stream 1,0,1 with no load:
  - o_detect stays 0 and o_armed = 0.
  - With i_rst held, every output is 0.
- Load pat=1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 with i_enable=1:
  - o_detect pulses on bits 4 and 7.
  - o_det_cnt = 2 (counter enabled).
- Same pattern with overlap=0, same stream:
  - Single pulse on bit 4.
  - Bits 5-7 refill only, so there is no detect on bit 7.
- Load pat=101, len=3, overlap=1; stream 1,0,1,0,1 with i_enable deasserted for two cycles between bits 2 and 3:
  - Pulses on bits 3 and 5 only.
  - No pulse while i_enable = 0.
- CNT_W=2, six matches, then i_cnt_clr asserted together with a seventh match:
  - o_det_cnt saturates at 3, then reads 0.
- Load mid-stream after 1,0 of pattern 101, reloading the same pattern:
  - The next 1 does not detect.
  - The full 1,0,1 is needed again.
  - i_len = MAX_LEN+3 behaves as MAX_LEN.

Source files
------------

// File: rtl/seq_det_prog_if.sv
// seq_det_prog_if: stream, pattern-load and status bundle of the
// programmable sequence detector.
// The master side (bit source / control) drives the i_* members and the
// slave side (the detector) drives the o_* members.
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               i_enable;
    logic               i_seq;
    logic               i_load;
    logic [MAX_LEN-1:0] i_pat;
    logic [LEN_W-1:0]   i_len;
    logic               i_overlap;
    logic               i_cnt_clr;
    logic               o_detect;
    logic               o_armed;
    logic [CNT_W-1:0]   o_det_cnt;

    modport master (
        output i_enable, i_seq, i_load, i_pat, i_len, i_overlap, i_cnt_clr,
        input  o_detect, o_armed, o_det_cnt
    );

    modport slave (
        input  i_enable, i_seq, i_load, i_pat, i_len, i_overlap, i_cnt_clr,
        output o_detect, o_armed, o_det_cnt
    );
endinterface

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable Mealy sequence detector.
// A pattern of 1..MAX_LEN bits is loaded with a one-cycle strobe; i_pat[len-1]
// is the first bit expected on the stream and i_pat[0] the last. o_detect is
// combinational and rises in the same cycle as the completing bit.
// Optional feature macro: SEQ_DET_CNT_EN builds a saturating match counter
// behind o_det_cnt; without it o_det_cnt is tied to zero.
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    seq_det_prog_if.slave bus
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int HIST_W = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Clamp an incoming length to the largest supported pattern.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] res;
        if (len > MAX_LEN_V) begin
            res = MAX_LEN_V;
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Bit mask selecting the low 'len' positions of a MAX_LEN-wide window.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (LEN_W'(i) < len);
        end
        return m;
    endfunction

    // Pattern configuration latched by a load.
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               armed_q, armed_d;

    // Match progress: previous bits (hist[0] newest) and bits since restart.
    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    state_e             state_q, state_d;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;
    logic               detect_s;
    logic               accept_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [LEN_W-1:0]   load_len_s;

    // Compare the newest len_r bits (history plus the current bit) against the pattern.
    always_comb begin
        window_s = {hist_q, bus.i_seq};
        mask_s   = len_mask(len_q);
        match_s  = (((window_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});
        accept_s = bus.i_enable & ~bus.i_load;
        detect_s = accept_s & (state_q == ST_RUN) & match_s;
    end

    // Next-state logic: load takes priority, otherwise consume the qualified bit.
    always_comb begin
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        armed_d    = armed_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        state_d    = state_q;
        load_len_s = clamp_len(bus.i_len);
        if (fill_q == MAX_LEN_V) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + LEN_ONE;
        end

        if (bus.i_load) begin
            // The bit presented with the load is discarded.
            pat_d   = bus.i_pat;
            len_d   = load_len_s;
            ovl_d   = bus.i_overlap;
            armed_d = (load_len_s != LEN_ZERO);
            hist_d  = {HIST_W{1'b0}};
            fill_d  = LEN_ZERO;
            if (load_len_s == LEN_ZERO) begin
                state_d = ST_IDLE;
            end else if (load_len_s == LEN_ONE) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_FILL;
            end
        end else if (bus.i_enable) begin
            // Shift left, new bit enters at hist[0]; the oldest bit falls off.
            hist_d = HIST_W'({hist_q, bus.i_seq});
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FILL: begin
                    fill_d = fill_inc_s;
                    if (fill_inc_s >= (len_q - LEN_ONE)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    // Non-overlapping mode restarts collection after a hit;
                    // a one-bit pattern has nothing to refill.
                    if (detect_s && !ovl_q && (len_q != LEN_ONE)) begin
                        fill_d  = LEN_ZERO;
                        state_d = ST_FILL;
                    end else begin
                        fill_d  = fill_inc_s;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    fill_d  = LEN_ZERO;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            // Stream stalled: everything holds.
            hist_d  = hist_q;
            fill_d  = fill_q;
            state_d = state_q;
        end
    end

    // Detector state register; reset drops configuration and progress at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pat_q   <= {MAX_LEN{1'b0}};
            len_q   <= LEN_ZERO;
            ovl_q   <= 1'b0;
            armed_q <= 1'b0;
            hist_q  <= {HIST_W{1'b0}};
            fill_q  <= LEN_ZERO;
            state_q <= ST_IDLE;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            armed_q <= armed_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    assign bus.o_detect = detect_s;
    assign bus.o_armed  = armed_q;

`ifdef SEQ_DET_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; a clear wins over a same-cycle detect.
    always_comb begin
        if (bus.i_cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (detect_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Match counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_det_cnt = cnt_q;
`else
    logic cnt_clr_unused_s;

    assign cnt_clr_unused_s = bus.i_cnt_clr;
    assign bus.o_det_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: randomized and directed checks of seq_det_prog against a
// queue-based reference model of the matching rules.
module tb_seq_det_prog;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_det_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_armed;
    int                 m_cnt;
    bit                 since[$];   // bits accepted since last restart, newest at back
    bit                 exp_det;

    initial begin
        m_pat = '0; m_len = 0; m_ovl = 0; m_armed = 0; m_cnt = 0; exp_det = 0;
    end

    // Compare process: evaluate the model a few time units before each rising edge.
    always begin : compare
        int  n;
        bit  match;
        bit  b;
        int  ln;
        @(negedge clk);
        #3;
        if (rst) begin
            exp_det = 0;
            chk("rst_detect", {31'd0, bus.o_detect}, 32'd0);
            chk("rst_armed", {31'd0, bus.o_armed}, 32'd0);
            chk("rst_cnt", 32'(bus.o_det_cnt), 32'd0);
            m_pat = '0; m_len = 0; m_ovl = 0; m_armed = 0; m_cnt = 0;
            since.delete();
        end else begin
            exp_det = 0;
            if (!bus.i_load && bus.i_enable && m_len > 0) begin
                n = since.size() + 1;
                if (n >= m_len) begin
                    match = 1;
                    for (int k = 0; k < m_len; k++) begin
                        b = (k == 0) ? bus.i_seq : since[since.size() - k];
                        if (b != m_pat[k]) match = 0;
                    end
                    exp_det = match;
                end
            end
            chk("detect", {31'd0, bus.o_detect}, {31'd0, exp_det});
            chk("armed", {31'd0, bus.o_armed}, {31'd0, m_armed});
            chk("det_cnt", 32'(bus.o_det_cnt), 32'(m_cnt));
            if (bus.i_load) begin
                ln = int'(bus.i_len);
                if (ln > MAX_LEN) ln = MAX_LEN;
                m_pat = bus.i_pat; m_len = ln; m_ovl = bus.i_overlap;
                m_armed = (ln != 0);
                since.delete();
            end else if (bus.i_enable) begin
                since.push_back(bus.i_seq);
                if (since.size() > MAX_LEN) void'(since.pop_front());
                if (exp_det && !m_ovl) since.delete();
            end
            if (CNT_ON != 0) begin
                if (bus.i_cnt_clr) m_cnt = 0;
                else if (exp_det && m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    logic got_det, got_mdl, got_armed;
    int   got_cnt;

    task automatic step(input logic r, input logic en, input logic sq, input logic ld,
                        input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o, input logic clr);
        @(negedge clk);
        #1;
        rst = r; bus.i_enable = en; bus.i_seq = sq; bus.i_load = ld;
        bus.i_pat = p; bus.i_len = l; bus.i_overlap = o; bus.i_cnt_clr = clr;
        #3;
        got_det = bus.o_detect; got_mdl = exp_det;
        got_armed = bus.o_armed; got_cnt = int'(bus.o_det_cnt);
    endtask

    task automatic bit_in(input logic sq, input logic clr = 1'b0);
        step(1'b0, 1'b1, sq, 1'b0, '0, '0, 1'b0, clr);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        step(1'b0, 1'b1, 1'b1, 1'b1, p, l, o, 1'b1);
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic exp_bit(input string name, input logic e);
        chk({name, "_dut"}, {31'd0, got_det}, {31'd0, e});
        chk({name, "_mdl"}, {31'd0, got_mdl}, {31'd0, e});
    endtask

    task automatic stream(input string name, input logic [15:0] bits, input logic [15:0] dets, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(bits[i]);
            exp_bit($sformatf("%s_b%0d", name, n - i), dets[i]);
        end
    endtask

    logic [MAX_LEN-1:0] rp;
    int                 rl;
    int                 fidx;
    logic               sq_r;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.i_enable = 1'b0; bus.i_seq = 1'b0; bus.i_load = 1'b0; bus.i_pat = '0;
        bus.i_len = '0; bus.i_overlap = 1'b0; bus.i_cnt_clr = 1'b0;

        // Reset held while bits stream in: all outputs zero.
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rst_held_armed", {31'd0, got_armed}, 32'd0);

        // No load: never detects, not armed.
        stream("noload", 16'b101, 16'b000, 3);
        chk("noload_armed", {31'd0, got_armed}, 32'd0);

        // 1011 overlapping: hits on bits 4 and 7.
        load(8'b1011, 4'd4, 1'b1);
        stream("ovl1011", 16'b1011011, 16'b0001001, 7);
        chk("ovl1011_armed", {31'd0, got_armed}, 32'd1);
        idle();
        chk("ovl1011_cnt", 32'(got_cnt), (CNT_ON != 0) ? 32'd2 : 32'd0);

        // 1011 non-overlapping: single hit on bit 4.
        load(8'b1011, 4'd4, 1'b0);
        stream("nov1011", 16'b1011011, 16'b0001000, 7);

        // 101 with two stalled cycles between bits 2 and 3.
        load(8'b101, 4'd3, 1'b1);
        stream("stall_a", 16'b10, 16'b00, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        exp_bit("stall_off1", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        exp_bit("stall_off2", 1'b0);
        stream("stall_b", 16'b101, 16'b101, 3);

        // Counter saturation with one-bit pattern, then clear beats a detect.
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1);
            exp_bit($sformatf("sat_b%0d", i + 1), 1'b1);
        end
        chk("sat_cnt", 32'(got_cnt), (CNT_ON != 0) ? 32'd3 : 32'd0);
        bit_in(1'b1, 1'b1);
        exp_bit("sat_b7", 1'b1);
        idle();
        chk("clr_cnt", 32'(got_cnt), 32'd0);

        // Reload mid-match drops progress.
        load(8'b101, 4'd3, 1'b1);
        stream("mid_a", 16'b10, 16'b00, 2);
        load(8'b101, 4'd3, 1'b1);
        exp_bit("mid_load", 1'b0);
        stream("mid_b", 16'b101, 16'b001, 3);

        // Oversized length clamps to MAX_LEN.
        load(8'b10110011, 4'(MAX_LEN + 3), 1'b0);
        stream("clamp", 16'b10110011, 16'b00000001, 8);
        chk("clamp_armed", {31'd0, got_armed}, 32'd1);

        // Length 0 disarms.
        load(8'b1, 4'd0, 1'b1);
        bit_in(1'b1);
        exp_bit("len0", 1'b0);
        chk("len0_armed", {31'd0, got_armed}, 32'd0);

        // Randomized phase, checked every cycle by the compare process.
        rp = 8'b101; rl = 3; fidx = 0;
        load(rp, 4'(rl), 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1'b1, 1'b1, 1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
                rl = 0;
            end else if ($urandom_range(0, 39) == 0) begin
                rp = MAX_LEN'($urandom);
                rl = $urandom_range(0, MAX_LEN + 3);
                fidx = 0;
                step(1'b0, 1'($urandom), 1'($urandom), 1'b1, rp, 4'(rl),
                     1'($urandom), ($urandom_range(0, 3) == 0));
                if (rl > MAX_LEN) rl = MAX_LEN;
            end else begin
                if (rl > 0 && $urandom_range(0, 4) != 0) begin
                    sq_r = rp[rl - 1 - fidx];
                    fidx = (fidx + 1) % rl;
                end else begin
                    sq_r = 1'($urandom);
                end
                step(1'b0, ($urandom_range(0, 3) != 0), sq_r, 1'b0, '0, '0, 1'b0,
                     ($urandom_range(0, 49) == 0));
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
